// File: rtl/dram_sched.sv
// rtl/dram_sched.sv - row-hit-first read scheduler in front of a single-bank row-buffer DRAM
// Issues one access at a time and self-times it from the tracked open row.
module dram_sched #(
  parameter int NREQ       = 4,
  parameter int ROWW       = 4,
  parameter int DATAW      = 32,
  parameter int T_HIT      = 1,
  parameter int T_MISS     = 20,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ROWW-1:0]    req_row,
  output logic [NREQ-1:0]         req_ready,
  output logic                    mem_valid,
  output logic [ROWW-1:0]         mem_row,
  input  logic [DATAW-1:0]        mem_y,
  output logic                    resp_valid,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [DATAW-1:0]        resp_data,
  output logic                    busy,
  output logic [ROWW-1:0]         open_row,
  output logic                    row_known
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(T_MISS + 1);
  localparam int SW  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr;
  logic [IDW-1:0]   r_id;
  logic [SW-1:0]    r_starve;
  logic [ROWW-1:0]  r_row;
  logic [ROWW-1:0]  r_open_row;
  logic             r_row_known;
  logic             r_mem_valid;
  logic             r_resp_valid;
  logic [CW-1:0]    r_lat;
  logic [CW-1:0]    r_cnt;
  logic [DATAW-1:0] r_resp_data;

  logic [NREQ-1:0]  w_hit;
  logic             w_nonhit_pend;
  logic             w_use_hit;
  logic             w_grant_en;
  logic             w_win_hit;
  logic [IDW-1:0]   w_hit_idx;
  logic [IDW-1:0]   w_rr_idx;
  logic [IDW-1:0]   w_j;
  logic [IDW-1:0]   w_win;
  logic [ROWW-1:0]  w_win_row;

  always_comb begin
    w_hit         = '0;
    w_nonhit_pend = 1'b0;
    w_hit_idx     = '0;
    w_rr_idx      = '0;
    w_j           = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (r_row_known && (req_row[i*ROWW +: ROWW] == r_open_row)) w_hit[i] = 1'b1;
        else w_nonhit_pend = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDW'(i);
    end
    // Scanning offsets downward leaves the nearest valid requester at or after r_rr.
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = IDW'((int'(r_rr) + k) % NREQ);
      if (req_valid[w_j]) w_rr_idx = w_j;
    end
    w_use_hit  = (|w_hit) && (int'(r_starve) < STARVE_MAX);
    w_win      = w_use_hit ? w_hit_idx : w_rr_idx;
    w_win_row  = req_row[w_win*ROWW +: ROWW];
    w_win_hit  = w_hit[w_win];
    w_grant_en = rstn && (r_state == S_IDLE) && (|req_valid);
    req_ready  = '0;
    if (w_grant_en) req_ready[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_rr         <= '0;
      r_id         <= '0;
      r_starve     <= '0;
      r_row        <= '0;
      r_open_row   <= '0;
      r_row_known  <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_lat        <= '0;
      r_cnt        <= '0;
      r_resp_data  <= '0;
    end else begin
      r_mem_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_id        <= w_win;
            r_row       <= w_win_row;
            r_lat       <= w_win_hit ? CW'(T_HIT) : CW'(T_MISS);
            r_mem_valid <= 1'b1;
            r_state     <= S_ISSUE;
            // A hit grant only happens below STARVE_MAX, so the increment saturates there.
            if (w_use_hit) begin
              r_starve <= w_nonhit_pend ? r_starve + SW'(1) : '0;
            end else begin
              r_starve <= '0;
              r_rr     <= (int'(w_win) == NREQ - 1) ? '0 : w_win + IDW'(1);
            end
          end
        end
        S_ISSUE: begin
          r_cnt       <= r_lat;
          r_open_row  <= r_row;
          r_row_known <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_resp_data  <= mem_y;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_valid  = r_mem_valid;
  assign mem_row    = r_row;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != S_IDLE);
  assign open_row   = r_open_row;
  assign row_known  = r_row_known;
endmodule

// File: tb/tb_dram_sched.sv
// tb/tb_dram_sched.sv - randomized self-checking bench for dram_sched against a grant-timeline model
// Includes a behavioural row-buffer DRAM whose data is only valid after its real latency.
module tb_dram_sched;
  localparam int NREQ = 4, ROWW = 4, DATAW = 32;
  localparam int T_HIT = 1, T_MISS = 20, STARVE_MAX = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*ROWW-1:0] req_row = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 mem_valid;
  logic [ROWW-1:0]      mem_row;
  logic [DATAW-1:0]     mem_y = '0;
  logic                 resp_valid;
  logic [1:0]           resp_id;
  logic [DATAW-1:0]     resp_data;
  logic                 busy;
  logic [ROWW-1:0]      open_row;
  logic                 row_known;

  int total = 0;
  int bad = 0;

  dram_sched #(.NREQ(NREQ), .ROWW(ROWW), .DATAW(DATAW), .T_HIT(T_HIT),
               .T_MISS(T_MISS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_row(req_row),
    .req_ready(req_ready), .mem_valid(mem_valid), .mem_row(mem_row), .mem_y(mem_y),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy),
    .open_row(open_row), .row_known(row_known)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] row_data(input int r);
    return DATAW'(r);
  endfunction

  function automatic int row_of(input int i);
    logic [NREQ*ROWW-1:0] t;
    t = req_row >> (i * ROWW);
    return int'(t[ROWW-1:0]);
  endfunction

  // DRAM: open-row hit answers next cycle, otherwise after T_MISS-1 cycles; garbage until then.
  int              dram_open = -1;
  int              dram_cnt = 0;
  logic [ROWW-1:0] dram_row = '0;
  always @(posedge clk) begin
    if (mem_valid) begin
      dram_row  <= mem_row;
      dram_open <= int'(mem_row);
      if (int'(mem_row) == dram_open) begin
        mem_y    <= row_data(int'(mem_row));
        dram_cnt <= 0;
      end else begin
        mem_y    <= 32'hBAD0_0000 | DATAW'($urandom_range(0, 255));
        dram_cnt <= T_MISS - 1;
      end
    end else if (dram_cnt > 0) begin
      dram_cnt <= dram_cnt - 1;
      if (dram_cnt == 1) mem_y <= row_data(int'(dram_row));
    end
  end

  int   cyc = 0;
  logic rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rstn;
  end

  bit              started = 1'b0;
  bit              m_known = 1'b0;
  int              m_open = 0, m_rr = 0, m_st = 0, m_id = 0, m_row = 0;
  int              m_free_at = 0, m_issue_at = -1, m_resp_at = -1;
  logic [NREQ-1:0] last_grant = '0;
  bit              last_resp = 1'b0;
  int              last_resp_id = 0;
  logic [NREQ-1:0] rereq_mask = '0;
  int              issue_cyc = 0;
  int              g_id_q[$], g_cyc_q[$], r_cyc_q[$], r_id_q[$];
  logic [DATAW-1:0] r_data_q[$];

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int  win, lat, hit_idx, rw;
    bit  any_hit, nonhit, use_hit;
    last_grant = '0;
    last_resp  = 1'b0;
    if (rst_edge) begin
      started = 1'b1; m_known = 1'b0; m_open = 0; m_rr = 0; m_st = 0;
      m_free_at = cyc; m_issue_at = -1; m_resp_at = -1;
      chk("rst_ctl", 32'({mem_valid, resp_valid, busy, row_known, resp_id}), 32'd0);
      chk("rst_rows", 32'({open_row, mem_row}), 32'd0);
      chk("rst_data", resp_data, 32'd0);
    end
    if (started) begin
      chk("mem_valid", 32'(mem_valid), 32'(cyc == m_issue_at));
      if (cyc == m_issue_at) begin
        chk("mem_row", 32'(mem_row), m_row);
        issue_cyc = cyc;
      end
      chk("resp_valid", 32'(resp_valid), 32'(cyc == m_resp_at));
      if (cyc == m_resp_at) begin
        chk("resp_id", 32'(resp_id), m_id);
        chk("resp_data", resp_data, row_data(m_row));
      end
      if (resp_valid) begin
        r_cyc_q.push_back(cyc); r_id_q.push_back(int'(resp_id)); r_data_q.push_back(resp_data);
        last_resp = 1'b1; last_resp_id = int'(resp_id);
      end
      chk("busy", 32'(busy), 32'(cyc < m_free_at));
      exp_ready = '0;
      if (cyc >= m_free_at) begin
        chk("row_known", 32'(row_known), 32'(m_known));
        if (m_known) chk("open_row", 32'(open_row), m_open);
        if (rstn && req_valid != '0) begin
          any_hit = 1'b0; nonhit = 1'b0; hit_idx = 0; win = -1;
          for (int i = NREQ - 1; i >= 0; i--) begin
            if (((req_valid >> i) & 1) != 0) begin
              if (m_known && row_of(i) == m_open) begin any_hit = 1'b1; hit_idx = i; end
              else nonhit = 1'b1;
            end
          end
          use_hit = any_hit && (m_st < STARVE_MAX);
          if (use_hit) win = hit_idx;
          else begin
            for (int k = 0; k < NREQ; k++)
              if (win < 0 && ((req_valid >> ((m_rr + k) % NREQ)) & 1) != 0) win = (m_rr + k) % NREQ;
          end
          rw  = row_of(win);
          lat = (m_known && rw == m_open) ? T_HIT : T_MISS;
          if (use_hit) m_st = nonhit ? m_st + 1 : 0;
          else begin m_rr = (win + 1) % NREQ; m_st = 0; end
          m_known = 1'b1; m_open = rw; m_id = win; m_row = rw;
          m_issue_at = cyc + 1; m_resp_at = cyc + lat + 2; m_free_at = cyc + lat + 3;
          exp_ready = NREQ'(1) << win;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (req_ready != '0) begin
        last_grant = req_ready;
        for (int i = 0; i < NREQ; i++) if (((req_ready >> i) & 1) != 0) g_id_q.push_back(i);
        g_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~last_grant;
    if (last_resp && ((rereq_mask >> last_resp_id) & 1) != 0)
      req_valid = req_valid | (NREQ'(1) << last_resp_id);
  endtask

  task automatic set_req(input int i, input int row);
    logic [NREQ*ROWW-1:0] m;
    m = {{(NREQ*ROWW-ROWW){1'b0}}, {ROWW{1'b1}}} << (i * ROWW);
    req_row   = (req_row & ~m) | ((NREQ*ROWW)'(row) << (i * ROWW));
    req_valid = req_valid | (NREQ'(1) << i);
  endtask

  task automatic run_resps(input int k, input int budget, input string tag);
    for (int n = 0; n < budget && r_cyc_q.size() < k; n++) step();
    chk(tag, r_cyc_q.size() >= k, 1);
  endtask

  task automatic wait_grant(input int k, input int budget, input string tag);
    for (int n = 0; n < budget && g_id_q.size() < k; n++) step();
    chk(tag, g_id_q.size() >= k, 1);
  endtask

  initial begin
    int gb, rb, n2;
    step(); step();
    rstn = 1'b1;

    gb = g_id_q.size(); rb = r_cyc_q.size();
    set_req(0, 5);
    run_resps(rb + 1, 60, "t1_resp");
    if (r_cyc_q.size() > rb && g_id_q.size() > gb) begin
      chk("t1_id", g_id_q[gb], 0);
      chk("t1_issue", issue_cyc - g_cyc_q[gb], 1);
      chk("t1_lat", r_cyc_q[rb] - g_cyc_q[gb], T_MISS + 2);
      chk("t1_data", r_data_q[rb], 5);
    end
    step();
    chk("t1_known", 32'(row_known), 1);
    chk("t1_open", 32'(open_row), 5);

    gb = g_id_q.size(); rb = r_cyc_q.size();
    set_req(2, 5);
    run_resps(rb + 1, 60, "t2_resp");
    if (r_cyc_q.size() > rb && g_id_q.size() > gb) begin
      chk("t2_lat", r_cyc_q[rb] - g_cyc_q[gb], 3);
      chk("t2_data", r_data_q[rb], 5);
      chk("t2_id", r_id_q[rb], 2);
    end

    req_valid = '0; rstn = 1'b0; step(); rstn = 1'b1;
    gb = g_id_q.size(); rb = r_cyc_q.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 7 + i);
    run_resps(rb + 4, 200, "t4_resp");
    if (r_cyc_q.size() >= rb + 4 && g_id_q.size() >= gb + 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("t4_order", g_id_q[gb + j], j);
        chk("t4_data", r_data_q[rb + j], 7 + j);
        chk("t4_lat", r_cyc_q[rb + j] - g_cyc_q[gb + j], T_MISS + 2);
      end
    end

    rb = r_cyc_q.size();
    set_req(2, 5);
    run_resps(rb + 1, 60, "t3_open");
    gb = g_id_q.size(); rb = r_cyc_q.size();
    rereq_mask = 4'b0010;
    set_req(1, 5); set_req(3, 9);
    run_resps(rb + 5, 200, "t3_resp");
    rereq_mask = '0; req_valid = '0;
    if (r_cyc_q.size() >= rb + 5 && g_id_q.size() >= gb + 5) begin
      for (int j = 0; j < 4; j++) chk("t3_hit_id", g_id_q[gb + j], 1);
      chk("t3_starve_id", g_id_q[gb + 4], 3);
      chk("t3_hitlat", r_cyc_q[rb] - g_cyc_q[gb], T_HIT + 2);
      chk("t3_misslat", r_cyc_q[rb + 4] - g_cyc_q[gb + 4], T_MISS + 2);
      chk("t3_data", r_data_q[rb + 4], 9);
    end
    step();

    gb = g_id_q.size(); rb = r_cyc_q.size();
    set_req(0, 6);
    wait_grant(gb + 1, 40, "t5_grant");
    repeat (5) step();
    rstn = 1'b0; step(); rstn = 1'b1;
    repeat (30) step();
    chk("t5_noresp", r_cyc_q.size(), rb);
    chk("t5_unknown", 32'(row_known), 0);
    gb = g_id_q.size(); rb = r_cyc_q.size();
    set_req(0, 6);
    run_resps(rb + 1, 60, "t5_resp");
    if (r_cyc_q.size() > rb && g_id_q.size() > gb) begin
      chk("t5_lat", r_cyc_q[rb] - g_cyc_q[gb], T_MISS + 2);
      chk("t5_data", r_data_q[rb], 6);
    end

    gb = g_id_q.size(); rb = r_cyc_q.size();
    set_req(1, 12);
    wait_grant(gb + 1, 40, "t6_grant");
    set_req(2, 13);
    repeat (4) step();
    req_valid = req_valid & ~(NREQ'(1) << 2);
    run_resps(rb + 1, 60, "t6_resp");
    repeat (5) step();
    n2 = 0;
    for (int j = gb; j < g_id_q.size(); j++) if (g_id_q[j] == 2) n2++;
    chk("t6_nogrant2", n2, 0);
    chk("t6_resps", r_cyc_q.size() - rb, 1);

    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (((req_valid >> i) & 1) == 0) begin
          if ($urandom_range(0, 7) == 0) set_req(i, int'($urandom_range(0, 3)));
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid = req_valid & ~(NREQ'(1) << i);
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0; step(); rstn = 1'b1;
      end
    end
    req_valid = '0;
    repeat (40) step();
    chk("end_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_sched.md
Name: dram_sched

Overview:
- Multi-requester scheduler in front of the single-bank row-buffer DRAM model (16 rows × 32 bit, `input_valid`/`rno`/`y` interface).
- Arbitrates up to NREQ read requesters and prefers requests that hit the currently open row.
- Issues one access at a time to the DRAM and self-times each access from its own open-row tracking, because the DRAM's `output_bit` is not a usable completion strobe.
- Returns the data with the winning requester's ID.

Parameters:
- NREQ, 4: number of requesters; must be at least 2. The round-robin pointer is $clog2(NREQ) bits wide.
- ROWW, 4: row-number width.
- DATAW, 32: data width.
- T_HIT, 1: wait cycles after issue when the request hits the open row.
- T_MISS, 20: wait cycles after issue when no row is open, the row is unknown, or the row differs. Must be at least the DRAM's worst-case latency in clock cycles.
- STARVE_MAX, 4: maximum number of consecutive row-hit grants while a non-hit request is pending.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rstn, input, 1: synchronous active-low reset.
- req_valid, input, NREQ: per-requester request; held high until granted, and may be withdrawn before grant.
- req_row, input, NREQ*ROWW: packed row numbers; requester i uses bits [i*ROWW +: ROWW]. Must be stable while req_valid is high.
- req_ready, output, NREQ: one-hot, one-cycle grant pulse.
- mem_valid, output, 1: drives the DRAM `input_valid`.
- mem_row, output, ROWW: drives the DRAM `rno`.
- mem_y, input, DATAW: from the DRAM `y`.
- resp_valid, output, 1: one-cycle response pulse.
- resp_id, output, $clog2(NREQ): ID of the requester being answered.
- resp_data, output, DATAW: read data.
- busy, output, 1: high in every state except IDLE.
- open_row, output, ROWW: currently tracked open row.
- row_known, output, 1: open_row is valid.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - State goes to IDLE; any in-flight access is discarded with no response.
  - All outputs go to 0: req_ready, mem_valid, mem_row, resp_valid, resp_id, resp_data, busy, open_row, row_known.
  - The round-robin pointer and the starvation counter are cleared to 0.
  - Because row_known=0, the first access after reset always uses T_MISS (the DRAM keeps its row across our reset).
- State machine: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE arbitration, evaluated every cycle:
  - A requester is a hit when req_valid[i]=1, row_known=1 and its row equals open_row.
  - If any hit exists and the starvation counter is below STARVE_MAX, grant the lowest-index hit.
  - Otherwise, if any request is valid, grant the first valid requester at or after the round-robin pointer, wrapping at NREQ.
  - With no valid request, stay in IDLE.
  - On grant: pulse req_ready for the winner in that same cycle, latch its ID and row, latch the latency, and go to ISSUE.
  - Latency is T_HIT for a hit, otherwise T_MISS.
- Round-robin pointer: set to the winner+1 (mod NREQ) on every non-hit grant; unchanged on a hit grant.
- Starvation counter:
  - Incremented on a hit grant when some other valid requester is a non-hit, saturating at STARVE_MAX.
  - Cleared on any non-hit grant.
  - Cleared on a hit grant when no non-hit requester is pending.
  - When the counter has reached STARVE_MAX, the next grant is made by round-robin even if hits exist.
- ISSUE (one cycle, call it cycle c):
  - mem_valid=1 and mem_row=latched row.
  - Load the wait counter with the latched latency.
  - Set open_row=latched row and row_known=1.
- WAIT:
  - mem_valid=0; decrement the counter each cycle.
  - On the cycle the counter reaches 1, capture mem_y into resp_data at that edge (the end of cycle c+L) and go to RESP.
- RESP: resp_valid=1 and resp_id=latched ID at cycle c+L+1, then return to IDLE. The next grant can therefore occur at c+L+2.
- Withdrawal: a request withdrawn before its grant is simply not considered. A request with req_valid=1 in the grant cycle is committed.
- Simultaneous events: only one grant per IDLE cycle. Requests arriving while the block is busy wait in IDLE arbitration.

Test Plan:
- Reset, then req0 on row 5 granted at cycle t:
  - req_ready[0] at t, mem_valid at t+1, resp_valid at t+22 with data 5.
  - Afterwards row_known=1 and open_row=5.
- Open row 5, then req2 on row 5:
  - Hit path: resp_valid exactly 3 cycles after the grant with data 5, resp_id=2.
- Open row 5; req1 on row 5 and req3 on row 9 both held, req1 re-requesting each time it is answered:
  - Exactly 4 hit grants to req1, then req3 is granted with miss latency and data 9.
- Idle, rows 7/8/9/10 requested on req0..req3 simultaneously:
  - Grant order is 0,1,2,3.
  - Data is 7,8,9,10, each response 22 cycles after its own grant.
- rstn=0 during WAIT of a miss access:
  - No resp_valid is issued; all outputs are 0 one cycle later.
  - The next request on the previously open row uses T_MISS.
- req_valid dropped before grant while another requester is busy being served:
  - That requester never receives req_ready, and no spurious resp_valid appears.
